// File: rtl/lcd_score_sequencer.sv
// lcd_score_sequencer: converts a score to BCD and streams address + 4 ASCII digits to the LCD write stage.
// Define LEADING_ZERO_BLANK_EN to send leading zero digits (not units) as spaces.
module lcd_score_sequencer #(
  parameter int         WAIT_CYCLES = 2000,
  parameter logic [6:0] DDRAM_ADDR  = 7'h4C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score_in,
  input  logic        score_valid,
  output logic        lcd_wr,
  output logic        lcd_rs,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CONVERT, SEND, WAIT, FINISH} state_t;
  state_t state_q, state_d;
  logic [15:0] bin_q, bin_d, bcd_q, bcd_d, pend_val_q, pend_val_d, sat_in, bcd_adj;
  logic pending_q, pending_d, busy_q, busy_d, wr_q, rs_q, rs_d, done_q;
  logic [7:0] data_q, data_d, chr;
  logic [3:0] conv_q, conv_d, dig;
  logic [2:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic blank;
  assign sat_in = score_in > 16'd9999 ? 16'd9999 : score_in;
  assign dig = idx_q == 3'd1 ? bcd_q[15:12] : idx_q == 3'd2 ? bcd_q[11:8] :
               idx_q == 3'd3 ? bcd_q[7:4] : bcd_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank = idx_q == 3'd1 ? bcd_q[15:12] == 4'd0 : idx_q == 3'd2 ? bcd_q[15:8] == 8'd0 :
                 idx_q == 3'd3 ? bcd_q[15:4] == 12'd0 : 1'b0;
`else
  assign blank = 1'b0;
`endif
  assign chr = blank ? 8'h20 : {4'h3, dig};
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    pending_d  = pending_q;
    pend_val_d = pend_val_q;
    busy_d     = busy_q;
    rs_d       = rs_q;
    data_d     = data_q;
    conv_d     = conv_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    if (busy_q && score_valid) begin
      pending_d  = 1'b1;
      pend_val_d = sat_in;
    end
    case (state_q)
      IDLE: if (score_valid) begin
        bin_d   = sat_in;
        bcd_d   = '0;
        conv_d  = '0;
        busy_d  = 1'b1;
        state_d = CONVERT;
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        conv_d = conv_q + 4'd1;
        if (conv_q == 4'd15) begin
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        rs_d    = idx_q != 3'd0;
        data_d  = idx_q == 3'd0 ? {1'b1, DDRAM_ADDR} : chr;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
        cnt_d = '0;
        if (idx_q == 3'd4) state_d = FINISH;
        else begin
          idx_d   = idx_q + 3'd1;
          state_d = SEND;
        end
      end else cnt_d = cnt_q + CW'(1);
      FINISH: if (pending_q || score_valid) begin
        // a request arriving on this very cycle is newer than any stored one
        bin_d     = score_valid ? sat_in : pend_val_q;
        bcd_d     = '0;
        conv_d    = '0;
        pending_d = 1'b0;
        state_d   = CONVERT;
      end else begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      pending_q  <= 1'b0;
      pend_val_q <= '0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      conv_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      pending_q  <= pending_d;
      pend_val_q <= pend_val_d;
      busy_q     <= busy_d;
      wr_q       <= state_q == SEND;
      rs_q       <= rs_d;
      data_q     <= data_d;
      done_q     <= state_q == FINISH;
      conv_q     <= conv_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end
  assign lcd_wr   = wr_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_lcd_score_sequencer.sv
// tb_lcd_score_sequencer: directed checks of byte stream, timing, pending and reset behaviour.
module tb_lcd_score_sequencer;
  logic clk = 1'b0, reset = 1'b1, score_valid = 1'b0;
  logic [15:0] score_in = '0;
  logic lcd_wr, lcd_rs, busy, done;
  logic [7:0] lcd_data;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [7:0] q_d[$];
  logic q_rs[$];
  int q_t[$], d_t[$];
  logic d_busy[$];
  lcd_score_sequencer #(.WAIT_CYCLES(4), .DDRAM_ADDR(7'h4C)) dut (
    .clk(clk), .reset(reset), .score_in(score_in), .score_valid(score_valid),
    .lcd_wr(lcd_wr), .lcd_rs(lcd_rs), .lcd_data(lcd_data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
    if (lcd_wr) begin
      q_d.push_back(lcd_data);
      q_rs.push_back(lcd_rs);
      q_t.push_back(cyc);
    end
    if (done) begin
      d_t.push_back(cyc);
      d_busy.push_back(busy);
    end
  endtask
  task automatic steps(input int n);
    repeat (n) step();
  endtask
  task automatic clr();
    q_d.delete(); q_rs.delete(); q_t.delete(); d_t.delete(); d_busy.delete();
  endtask
  task automatic pulse(input logic [15:0] s, output int c0);
    score_in = s;
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
    c0 = cyc;
  endtask
  task automatic check_seq(input string nm, input int c0, input int base,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] e[5];
    e = '{8'hCC, a, b, c, d};
    for (int i = 0; i < 5; i++)
      if (base + i < q_d.size()) begin
        chk($sformatf("%s_data%0d", nm, i), q_d[base+i], e[i]);
        chk($sformatf("%s_rs%0d", nm, i), q_rs[base+i], i != 0);
        chk($sformatf("%s_time%0d", nm, i), q_t[base+i], c0 + 17 + 5 * i);
      end else chk($sformatf("%s_missing%0d", nm, i), q_d.size(), base + 5);
  endtask
  task automatic do_seq(input string nm, input logic [15:0] s,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    int c0;
    clr();
    pulse(s, c0);
    steps(60);
    chk({nm, "_count"}, q_d.size(), 5);
    check_seq(nm, c0, 0, a, b, c, d);
    chk({nm, "_done_count"}, d_t.size(), 1);
    if (d_t.size() > 0) begin
      chk({nm, "_done_time"}, d_t[0], c0 + 42);
      chk({nm, "_busy_at_done"}, d_busy[0], 0);
    end
  endtask
  initial begin
    int c0, t;
    steps(2);
    reset = 1'b0;
    step();
    chk("rst_wr", lcd_wr, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    do_seq("basic", 16'd1234, 8'h31, 8'h32, 8'h33, 8'h34);
`ifdef LEADING_ZERO_BLANK_EN
    do_seq("zero", 16'd0, 8'h20, 8'h20, 8'h20, 8'h30);
`else
    do_seq("zero", 16'd0, 8'h30, 8'h30, 8'h30, 8'h30);
`endif
    do_seq("sat", 16'd12000, 8'h39, 8'h39, 8'h39, 8'h39);
    clr();
    pulse(16'd5, c0);
    steps(5);
    pulse(16'd77, t);
    steps(8);
    pulse(16'd88, t);
    steps(110);
    chk("pend_count", q_d.size(), 10);
`ifdef LEADING_ZERO_BLANK_EN
    check_seq("pend1", c0, 0, 8'h20, 8'h20, 8'h20, 8'h35);
    check_seq("pend2", c0 + 42, 5, 8'h20, 8'h20, 8'h38, 8'h38);
`else
    check_seq("pend1", c0, 0, 8'h30, 8'h30, 8'h30, 8'h35);
    check_seq("pend2", c0 + 42, 5, 8'h30, 8'h30, 8'h38, 8'h38);
`endif
    chk("pend_done_count", d_t.size(), 2);
    if (d_t.size() == 2) begin
      chk("pend_busy_first_done", d_busy[0], 1);
      chk("pend_busy_second_done", d_busy[1], 0);
    end
    clr();
    pulse(16'd2, c0);
    while (cyc < c0 + 41) step();
    pulse(16'd9, t);
    steps(100);
    chk("fin_count", q_d.size(), 10);
`ifdef LEADING_ZERO_BLANK_EN
    check_seq("fin1", c0, 0, 8'h20, 8'h20, 8'h20, 8'h32);
    check_seq("fin2", c0 + 42, 5, 8'h20, 8'h20, 8'h20, 8'h39);
`else
    check_seq("fin1", c0, 0, 8'h30, 8'h30, 8'h30, 8'h32);
    check_seq("fin2", c0 + 42, 5, 8'h30, 8'h30, 8'h30, 8'h39);
`endif
    clr();
    pulse(16'd6, c0);
    while (cyc < c0 + 22) step();
    chk("wr_before_rst", lcd_wr, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_wr", lcd_wr, 0);
    chk("async_rst_rs", lcd_rs, 0);
    chk("async_rst_data", lcd_data, 0);
    chk("async_rst_busy", busy, 0);
    steps(3);
    reset = 1'b0;
    clr();
    steps(40);
    chk("post_rst_no_wr", q_d.size(), 0);
    chk("post_rst_no_done", d_t.size(), 0);
    do_seq("fresh", 16'd4321, 8'h34, 8'h33, 8'h32, 8'h31);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
